gnr_node_lut: RTL and testbench

// - Generic gene-regulatory-network node. Its next state comes from a run-time loadable truth table (LUT), not from a hard-coded boolean expression.
// - Keeps two trajectories for attractor/cycle detection: s1 (fast, updates on every start_s1) and s0 (slow, updates once per SLOW_DIV start_s0 pulses).
// - Adds per-node modes (normal / knock-out / forced-on / frozen), a config lock FSM and a fast-step counter.
// - One instance per network node. The network top wires node outputs to other nodes' in_s0/in_s1.

---
 rtl/gnr_pkg.sv | 38 +++
 rtl/gnr_lut_eval.sv | 45 ++++
 rtl/gnr_node_lut.sv | 142 ++++++++++++++
 tb/tb_gnr_node_lut.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gnr_pkg.sv
// Shared definitions for the gene-regulatory-network node slice.
//   - node mode encodings (captured on config commit)
//   - config/run FSM state type
//   - elaboration-time helpers for LUT sizing
package gnr_pkg;

  localparam logic [1:0] MODE_NORMAL = 2'b00;  // LUT value
  localparam logic [1:0] MODE_KO     = 2'b01;  // knock-out: always 0
  localparam logic [1:0] MODE_ON     = 2'b10;  // forced-on: always 1
  localparam logic [1:0] MODE_FREEZE = 2'b11;  // hold current state

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } gnr_state_e;

  function automatic int gnr_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Number of CFG_W-bit words needed to hold a 2**num_in entry LUT.
  function automatic int gnr_num_words(input int num_in, input int cfg_w);
    return ((1 << num_in) + cfg_w - 1) / cfg_w;
  endfunction

  // Word address width, never below 1 so the port always exists.
  function automatic int gnr_addr_w(input int num_in, input int cfg_w);
    int w;
    w = gnr_clog2(gnr_num_words(num_in, cfg_w));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gnr_lut_eval.sv
// LUT storage for one node plus two combinational read ports.
//   clk, rst_n      clock / async active-low reset (LUT clears to 0)
//   wr_en           write the word at wr_addr
//   wr_addr         word index; indices past the last word match nothing
//   wr_data         CFG_W bits for LUT[wr_addr*CFG_W +: CFG_W]
//   idx_s0/idx_s1   regulator vectors for the slow / fast trajectory
//   bit_s0/bit_s1   LUT entries at those indices
module gnr_lut_eval
  import gnr_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int CFG_W  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  wr_en,
  input  logic [gnr_addr_w(NUM_IN, CFG_W)-1:0]  wr_addr,
  input  logic [CFG_W-1:0]                      wr_data,
  input  logic [NUM_IN-1:0]                     idx_s0,
  input  logic [NUM_IN-1:0]                     idx_s1,
  output logic                                  bit_s0,
  output logic                                  bit_s1
);

  localparam int LUT_N  = 1 << NUM_IN;
  localparam int ADDR_W = gnr_addr_w(NUM_IN, CFG_W);

  // Only the 2**NUM_IN live bits are stored; padding bits of the last word
  // are never kept, so they cannot leak into a read.
  logic [LUT_N-1:0] lut_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < LUT_N; i++)
        if (wr_addr == ADDR_W'(i / CFG_W))
          lut_q[i] <= wr_data[i % CFG_W];
    end
  end

  assign bit_s0 = lut_q[idx_s0];
  assign bit_s1 = lut_q[idx_s1];

endmodule

// File: rtl/gnr_node_lut.sv
// Generic GRN node: next state read from a run-time loaded truth table.
// Two trajectories share one LUT: s1 steps on every start_s1, s0 steps once
// per SLOW_DIV start_s0 pulses, for attractor/cycle detection.
//   cfg_valid/ready/addr/data  LUT word write, accepted only in IDLE
//   cfg_mode/cfg_init          captured on cfg_commit (IDLE -> ARMED)
//   cfg_unlock                 any state -> IDLE, trajectories hold
//   reset_nos                  ARMED/RUN: load init into s0/s1, go RUN
//   start_s0/start_s1          trajectory step strobes (RUN only)
//   in_s0/in_s1                regulator states for each trajectory
//   s0/s1                      registered node states
//   armed/running              FSM status
//   steps_s1                   saturating count of s1 updates
module gnr_node_lut
  import gnr_pkg::*;
#(
  parameter int NUM_IN   = 4,
  parameter int CFG_W    = 8,
  parameter int SLOW_DIV = 2,
  parameter int STEP_W   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [gnr_addr_w(NUM_IN, CFG_W)-1:0]  cfg_addr,
  input  logic [CFG_W-1:0]                      cfg_data,
  input  logic [1:0]                            cfg_mode,
  input  logic                                  cfg_init,
  input  logic                                  cfg_commit,
  input  logic                                  cfg_unlock,
  input  logic                                  reset_nos,
  input  logic                                  start_s0,
  input  logic                                  start_s1,
  input  logic [NUM_IN-1:0]                     in_s0,
  input  logic [NUM_IN-1:0]                     in_s1,
  output logic                                  s0,
  output logic                                  s1,
  output logic                                  armed,
  output logic                                  running,
  output logic [STEP_W-1:0]                     steps_s1
);

  localparam int DIV_W = (SLOW_DIV > 1) ? gnr_clog2(SLOW_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOW_DIV - 1);

  gnr_state_e        state_q;
  logic [1:0]        mode_q;
  logic              init_q;
  logic              s0_q, s1_q;
  logic [DIV_W-1:0]  div_q;
  logic [STEP_W-1:0] steps_q;

  logic lut_s0, lut_s1, nxt_s0, nxt_s1;
  logic cfg_we, do_nos, do_run;

  assign cfg_ready = (state_q == ST_IDLE);
  assign cfg_we    = cfg_valid & cfg_ready;
  // unlock outranks reset_nos, which outranks the start strobes
  assign do_nos    = !cfg_unlock && reset_nos && (state_q != ST_IDLE);
  assign do_run    = !cfg_unlock && !reset_nos && (state_q == ST_RUN);

  gnr_lut_eval #(.NUM_IN(NUM_IN), .CFG_W(CFG_W)) u_lut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cfg_we),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .idx_s0  (in_s0),
    .idx_s1  (in_s1),
    .bit_s0  (lut_s0),
    .bit_s1  (lut_s1)
  );

  function automatic logic apply_mode(input logic [1:0] m, input logic lut_bit,
                                      input logic cur);
    case (m)
      MODE_NORMAL: return lut_bit;
      MODE_KO:     return 1'b0;
      MODE_ON:     return 1'b1;
      MODE_FREEZE: return cur;
      default:     return cur;
    endcase
  endfunction

  assign nxt_s0 = apply_mode(mode_q, lut_s0, s0_q);
  assign nxt_s1 = apply_mode(mode_q, lut_s1, s1_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_NORMAL;
      init_q  <= 1'b0;
    end else if (cfg_unlock) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cfg_commit) begin
          state_q <= ST_ARMED;
          mode_q  <= cfg_mode;
          init_q  <= cfg_init;
        end
        ST_ARMED, ST_RUN: if (reset_nos) state_q <= ST_RUN;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      div_q   <= '0;
      steps_q <= '0;
    end else if (do_nos) begin
      s0_q    <= init_q;
      s1_q    <= init_q;
      steps_q <= '0;
      // primed so the first start_s0 after reset_nos always updates
      div_q   <= DIV_LAST;
    end else if (do_run) begin
      if (start_s1) begin
        s1_q <= nxt_s1;
        if (steps_q != '1) steps_q <= steps_q + STEP_W'(1);
      end
      if (start_s0) begin
        if (div_q == DIV_LAST) begin
          s0_q  <= nxt_s0;
          div_q <= '0;
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
      end
    end
  end

  assign s0       = s0_q;
  assign s1       = s1_q;
  assign armed    = (state_q == ST_ARMED);
  assign running  = (state_q == ST_RUN);
  assign steps_s1 = steps_q;

endmodule

// File: tb/tb_gnr_node_lut.sv
// Directed bench for gnr_node_lut. Two instances share stimulus: dut uses
// STEP_W=16, dut2 uses STEP_W=2 to exercise step-counter saturation.
// LUT under test: a & (b|c) & d with in[0..3] = {a,b,c,d} -> 16'hA800.
module tb_gnr_node_lut;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid, cfg_commit, cfg_unlock, cfg_init;
  logic [0:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [1:0] cfg_mode;
  logic       reset_nos, start_s0, start_s1;
  logic [3:0] in_s0, in_s1;

  logic        cfg_ready, s0, s1, armed, running;
  logic [15:0] steps_s1;
  logic        cfg_ready2, s0_2, s1_2, armed2, running2;
  logic [1:0]  steps2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gnr_node_lut #(.NUM_IN(4), .CFG_W(8), .SLOW_DIV(2), .STEP_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_mode(cfg_mode),
    .cfg_init(cfg_init), .cfg_commit(cfg_commit), .cfg_unlock(cfg_unlock),
    .reset_nos(reset_nos), .start_s0(start_s0), .start_s1(start_s1),
    .in_s0(in_s0), .in_s1(in_s1), .s0(s0), .s1(s1), .armed(armed),
    .running(running), .steps_s1(steps_s1)
  );

  gnr_node_lut #(.NUM_IN(4), .CFG_W(8), .SLOW_DIV(2), .STEP_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_mode(cfg_mode),
    .cfg_init(cfg_init), .cfg_commit(cfg_commit), .cfg_unlock(cfg_unlock),
    .reset_nos(reset_nos), .start_s0(start_s0), .start_s1(start_s1),
    .in_s0(in_s0), .in_s1(in_s1), .s0(s0_2), .s1(s1_2), .armed(armed2),
    .running(running2), .steps_s1(steps2)
  );

  typedef struct {
    logic [1:0] mode;
    logic       init;
    logic [3:0] in;
    int         pulses;
    logic       exp_s1;
    int         exp_steps;
    int         exp_steps2;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic a, input logic [7:0] d);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic commit(input logic [1:0] m, input logic i);
    cfg_mode = m; cfg_init = i; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic nos;
    reset_nos = 1'b1;
    tick();
    reset_nos = 1'b0;
  endtask

  task automatic unlock;
    cfg_unlock = 1'b1;
    tick();
    cfg_unlock = 1'b0;
  endtask

  task automatic step1(input logic [3:0] x);
    in_s1 = x; start_s1 = 1'b1;
    tick();
    start_s1 = 1'b0;
  endtask

  task automatic step0(input logic [3:0] x);
    in_s0 = x; start_s0 = 1'b1;
    tick();
    start_s0 = 1'b0;
  endtask

  initial begin
    //          mode   init in       n  s1    st st2
    vecs[0] = '{2'b00, 1'b0, 4'b1011, 1, 1'b1, 1, 1};
    vecs[1] = '{2'b00, 1'b1, 4'b1001, 1, 1'b0, 1, 1};
    vecs[2] = '{2'b00, 1'b0, 4'b1101, 2, 1'b1, 2, 2};
    vecs[3] = '{2'b00, 1'b1, 4'b0111, 1, 1'b0, 1, 1};
    vecs[4] = '{2'b01, 1'b1, 4'b1111, 1, 1'b0, 1, 1};
    vecs[5] = '{2'b10, 1'b0, 4'b0000, 1, 1'b1, 1, 1};
    vecs[6] = '{2'b11, 1'b1, 4'b0000, 5, 1'b1, 5, 3};
    vecs[7] = '{2'b11, 1'b0, 4'b1111, 3, 1'b0, 3, 3};

    rst_n = 1'b0;
    cfg_valid = 0; cfg_addr = 0; cfg_data = 0; cfg_mode = 0; cfg_init = 0;
    cfg_commit = 0; cfg_unlock = 0; reset_nos = 0; start_s0 = 0; start_s1 = 0;
    in_s0 = 0; in_s1 = 0;
    repeat (2) tick();

    // reset state
    chk("rst_s0", s0, 0);
    chk("rst_s1", s1, 0);
    chk("rst_armed", armed, 0);
    chk("rst_running", running, 0);
    chk("rst_steps", steps_s1, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst_n = 1'b1;
    tick();

    // load w0, then w1 in the same cycle as commit (write lands first)
    cfg_write(1'b0, 8'h00);
    cfg_valid = 1'b1; cfg_addr = 1'b1; cfg_data = 8'hA8;
    commit(2'b00, 1'b0);
    cfg_valid = 1'b0;
    chk("armed_after_commit", armed, 1);
    chk("cfg_ready_armed", cfg_ready, 0);
    step1(4'b1011);
    chk("armed_start_ignored_s1", s1, 0);
    chk("armed_start_ignored_steps", steps_s1, 0);
    nos();
    chk("running_after_nos", running, 1);
    step1(4'b1011);
    chk("first_step_s1", s1, 1);
    chk("first_step_steps", steps_s1, 1);

    // table: each vector re-commits mode/init, resets the trajectory, steps
    for (int v = 0; v < 8; v++) begin
      unlock();
      commit(vecs[v].mode, vecs[v].init);
      nos();
      chk($sformatf("v%0d_init", v), s1, vecs[v].init);
      chk($sformatf("v%0d_steps0", v), steps_s1, 0);
      for (int p = 0; p < vecs[v].pulses; p++) step1(vecs[v].in);
      chk($sformatf("v%0d_s1", v), s1, vecs[v].exp_s1);
      chk($sformatf("v%0d_steps", v), steps_s1, vecs[v].exp_steps);
      chk($sformatf("v%0d_steps_sat", v), steps2, vecs[v].exp_steps2);
    end

    // slow trajectory: updates on pulses 1 and 3; fast step in parallel
    unlock();
    commit(2'b00, 1'b0);
    nos();
    in_s1 = 4'b1011; start_s1 = 1'b1;
    step0(4'b1111);
    start_s1 = 1'b0;
    chk("slow_p1_s0", s0, 1);
    chk("slow_p1_par_s1", s1, 1);
    chk("slow_p1_par_steps", steps_s1, 1);
    step0(4'b0000);
    chk("slow_p2_hold", s0, 1);
    step0(4'b0000);
    chk("slow_p3_update", s0, 0);
    step0(4'b1111);
    chk("slow_p4_hold", s0, 0);

    // config write blocked in RUN, applied after unlock
    cfg_valid = 1'b1; cfg_addr = 1'b1; cfg_data = 8'hFF;
    chk("run_cfg_ready", cfg_ready, 0);
    tick();
    cfg_valid = 1'b0;
    step1(4'b1001);
    chk("run_write_dropped", s1, 0);
    unlock();
    chk("unlock_cfg_ready", cfg_ready, 1);
    chk("unlock_running", running, 0);
    chk("unlock_s1_hold", s1, 0);
    cfg_write(1'b1, 8'hFF);
    step1(4'b1001);
    chk("idle_start_s1", s1, 0);
    chk("idle_start_steps", steps_s1, 2);
    commit(2'b00, 1'b0);
    nos();
    step1(4'b1001);
    chk("unlocked_write_applied", s1, 1);

    // reset_nos beats start_s1 in the same cycle
    in_s1 = 4'b1011; start_s1 = 1'b1; reset_nos = 1'b1;
    tick();
    start_s1 = 1'b0; reset_nos = 1'b0;
    chk("nos_vs_start_s1", s1, 0);
    chk("nos_vs_start_steps", steps_s1, 0);
    chk("nos_vs_start_steps2", steps2, 0);

    // async reset mid-RUN, between clock edges
    step0(4'b1111);
    step1(4'b1011);
    chk("pre_arst_s0", s0, 1);
    chk("pre_arst_s1", s1, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_s0", s0, 0);
    chk("arst_s1", s1, 0);
    chk("arst_running", running, 0);
    chk("arst_cfg_ready", cfg_ready, 1);
    chk("arst_steps", steps_s1, 0);
    #1 rst_n = 1'b1;
    tick();
    commit(2'b00, 1'b1);
    nos();
    chk("post_arst_init", s1, 1);
    step1(4'b1111);
    chk("post_arst_lut_zero", s1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
